// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM encoding, key width,
// status bit positions and small decode helpers for active-low buses.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_e;

   localparam int KEY_W    = 4;

   localparam int ST_VALID = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;

   localparam logic [3:0] ROW_RST = 4'b1110;

   // True when exactly one line of an active-low bus is asserted.
   function automatic logic single_low(input logic [3:0] v);
      return ($countones(~v) == 1);
   endfunction

   // Index of the lowest asserted (low) line of an active-low bus.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key codes. A pop on empty is ignored; a push
// on full is accepted only when a pop frees a slot in the same cycle.
module key_fifo #(
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage write; contents are qualified by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad front end: row scanner with press/release debounce, key code
// queue, and a CPU read port (status or FIFO head) with edge-detected pop.
module keypad_scan_fifo
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 50000,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [3:0]       rowwrite,
   input  logic [3:0]       colread,
   input  logic             ack,
   input  logic             statusordata,
   output logic [KEY_W-1:0] keyout
);

   localparam int SC_W = $clog2(SCAN_DIV + 1);
   localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);

   kp_state_e        state_q, state_d;
   logic [3:0]       row_q, row_d;
   logic [SC_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [3:0]       col_q, col_d;
   logic [KEY_W-1:0] code_q, code_d;
   logic             push_q, push_d;
   logic             ack_d;
   logic             ovf_q;
   logic             pop;
   logic [KEY_W-1:0] head;
   logic             empty;
   logic             full;
   logic [KEY_W-1:0] status;

   assign rowwrite = row_q;

   // Scanner next-state and counter updates.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      scan_cnt_d = scan_cnt_q;
      db_cnt_d   = db_cnt_q;
      col_d      = col_q;
      code_d     = code_q;
      push_d     = 1'b0;
      unique case (state_q)
         SCAN: begin
            if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
               scan_cnt_d = '0;
               // Ghosted (multi-low) or idle columns just advance the scan.
               if (single_low(colread)) begin
                  col_d    = colread;
                  code_d   = {low_idx(row_q), low_idx(colread)};
                  db_cnt_d = '0;
                  state_d  = PRESS_DB;
               end else begin
                  row_d = {row_q[2:0], row_q[3]};
               end
            end else begin
               scan_cnt_d = scan_cnt_q + SC_W'(1);
            end
         end
         PRESS_DB: begin
            if (colread != col_q) begin
               scan_cnt_d = '0;
               state_d    = SCAN;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
               push_d  = 1'b1;
               state_d = HELD;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         HELD: begin
            if (colread == 4'hF) begin
               db_cnt_d = '0;
               state_d  = REL_DB;
            end
         end
         REL_DB: begin
            if (colread != 4'hF) begin
               state_d = HELD;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) begin
               row_d      = {row_q[2:0], row_q[3]};
               scan_cnt_d = '0;
               state_d    = SCAN;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   // Scanner control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCAN;
         row_q      <= ROW_RST;
         scan_cnt_q <= '0;
         db_cnt_q   <= '0;
         push_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         scan_cnt_q <= scan_cnt_d;
         db_cnt_q   <= db_cnt_d;
         push_q     <= push_d;
      end
   end

   // Latched column pattern and key code of the candidate press.
   always_ff @(posedge clk) begin
      col_q  <= col_d;
      code_q <= code_d;
   end

   // One pop per rising edge of ack, only when there is something to pop.
   assign pop = ack & ~ack_d & ~empty;

   // Ack edge detector and sticky overflow; a dropping push beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_d <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         ack_d <= ack;
         if (push_q & full & ~pop) ovf_q <= 1'b1;
         else if (pop)             ovf_q <= 1'b0;
      end
   end

   key_fifo #(
      .DATA_W     (KEY_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .pop   (pop),
      .din   (code_q),
      .head  (head),
      .empty (empty),
      .full  (full)
   );

   // CPU read mux: status word or FIFO head (zero when empty).
   always_comb begin
      status           = '0;
      status[ST_VALID] = ~empty;
      status[ST_FULL]  = full;
      status[ST_OVF]   = ovf_q;
      if (statusordata) keyout = status;
      else if (empty)   keyout = '0;
      else              keyout = head;
   end

endmodule
